// File: rtl/wb_core_arbiter.sv
// Two-master to one-slave Wishbone classic arbiter.
// m0 carries core data traffic, m1 carries instruction fetch. A grant is held
// for the whole CYC, transfers are forwarded combinationally, and a stalled
// transfer is aborted after TIMEOUT_CYCLES cycles without ACK/ERR.
module wb_core_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ROUND_ROBIN    = 1
) (
  input  logic                clk,
  input  logic                rstn_i,
  // master 0 (core data)
  input  logic                m0_cyc_i,
  input  logic                m0_stb_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_adr_i,
  input  logic [DATA_W-1:0]   m0_dat_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  output logic [DATA_W-1:0]   m0_dat_o,
  output logic                m0_ack_o,
  output logic                m0_err_o,
  // master 1 (instruction fetch)
  input  logic                m1_cyc_i,
  input  logic                m1_stb_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_adr_i,
  input  logic [DATA_W-1:0]   m1_dat_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  output logic [DATA_W-1:0]   m1_dat_o,
  output logic                m1_ack_o,
  output logic                m1_err_o,
  // slave side
  output logic                s_cyc_o,
  output logic                s_stb_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_adr_o,
  output logic [DATA_W-1:0]   s_dat_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  input  logic [DATA_W-1:0]   s_dat_i,
  input  logic                s_ack_i,
  input  logic                s_err_i,
  // one-hot current grant, bit0 = m0
  output logic [1:0]          grant_o
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The abort fires on the stall cycle that would bring the count to TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  state_t           state;
  logic             last_m1;
  logic [CNT_W-1:0] tmo_cnt;
  logic             act_cyc;
  logic             act_stb;
  logic             stalled;
  logic             timeout;

  // Request lines of the currently granted master, plus stall/timeout detection.
  always_comb begin
    act_cyc = 1'b0;
    act_stb = 1'b0;
    if (state == GNT0) begin
      act_cyc = m0_cyc_i;
      act_stb = m0_stb_i;
    end else if (state == GNT1) begin
      act_cyc = m1_cyc_i;
      act_stb = m1_stb_i;
    end
    stalled = act_cyc && act_stb && !s_ack_i && !s_err_i;
    timeout = (TIMEOUT_CYCLES != 0) && stalled && (tmo_cnt == TMO_LAST);
  end

  // Arbitration FSM; grant, last-grant pointer and stall counter are registered here.
  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      state   <= IDLE;
      grant_o <= 2'b00;
      last_m1 <= 1'b1;
      tmo_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (m0_cyc_i && m1_cyc_i) begin
            if ((ROUND_ROBIN != 0) && !last_m1) begin
              state   <= GNT1;
              grant_o <= 2'b10;
            end else begin
              state   <= GNT0;
              grant_o <= 2'b01;
            end
          end else if (m0_cyc_i) begin
            state   <= GNT0;
            grant_o <= 2'b01;
          end else if (m1_cyc_i) begin
            state   <= GNT1;
            grant_o <= 2'b10;
          end
        end
        GNT0, GNT1: begin
          if (!act_cyc) begin
            state   <= IDLE;
            grant_o <= 2'b00;
            last_m1 <= (state == GNT1);
            tmo_cnt <= '0;
          end else if (timeout) begin
            state   <= ABORT;
            tmo_cnt <= '0;
          end else if (stalled) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end else begin
            tmo_cnt <= '0;
          end
        end
        ABORT: begin
          if (!(grant_o[1] ? m1_cyc_i : m0_cyc_i)) begin
            state   <= IDLE;
            last_m1 <= grant_o[1];
            grant_o <= 2'b00;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= 2'b00;
        end
      endcase
    end
  end

  // Combinational request/response routing for the granted master; everything else sees zeros.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i || timeout;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i || timeout;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_core_arbiter.sv
// Self-checking bench for wb_core_arbiter: a round-robin instance with a short
// timeout is fully checked, a fixed-priority twin on the same inputs has its
// grant checked during the contention sequence.
`timescale 1ns/1ps
module tb_wb_core_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  localparam logic [ADDR_W-1:0] M0_ADR = 32'h0000_0100;
  localparam logic [DATA_W-1:0] M0_DAT = 32'h0000_A0A0;
  localparam logic [SEL_W-1:0]  M0_SEL = 4'b0011;
  localparam logic [ADDR_W-1:0] M1_ADR = 32'h0000_0200;
  localparam logic [DATA_W-1:0] M1_DAT = 32'h0000_B1B1;
  localparam logic [SEL_W-1:0]  M1_SEL = 4'b1100;
  localparam logic [DATA_W-1:0] S_DAT  = 32'hDEAD_BEEF;

  // expected routing of the round-robin instance
  localparam logic [1:0] F_NONE = 2'd0;
  localparam logic [1:0] F_M0   = 2'd1;
  localparam logic [1:0] F_M1   = 2'd2;
  localparam logic [1:0] F_ABT  = 2'd3;

  typedef struct packed {
    logic       rstn;
    logic [2:0] m0;
    logic [2:0] m1;
    logic [1:0] se;
    logic [1:0] fwd;
    logic [1:0] gnt;
    logic [3:0] ae;
    logic [2:0] fp;
  } vec_t;

  logic              clk;
  logic              rstn_i;
  logic              m0_cyc_i, m0_stb_i, m0_we_i;
  logic [ADDR_W-1:0] m0_adr_i;
  logic [DATA_W-1:0] m0_dat_i;
  logic [SEL_W-1:0]  m0_sel_i;
  logic [DATA_W-1:0] m0_dat_o;
  logic              m0_ack_o, m0_err_o;
  logic              m1_cyc_i, m1_stb_i, m1_we_i;
  logic [ADDR_W-1:0] m1_adr_i;
  logic [DATA_W-1:0] m1_dat_i;
  logic [SEL_W-1:0]  m1_sel_i;
  logic [DATA_W-1:0] m1_dat_o;
  logic              m1_ack_o, m1_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [ADDR_W-1:0] s_adr_o;
  logic [DATA_W-1:0] s_dat_o;
  logic [SEL_W-1:0]  s_sel_o;
  logic [DATA_W-1:0] s_dat_i;
  logic              s_ack_i, s_err_i;
  logic [1:0]        grant_o;

  logic [DATA_W-1:0] fp_m0_dat_o, fp_m1_dat_o;
  logic              fp_m0_ack_o, fp_m0_err_o, fp_m1_ack_o, fp_m1_err_o;
  logic              fp_s_cyc_o, fp_s_stb_o, fp_s_we_o;
  logic [ADDR_W-1:0] fp_s_adr_o;
  logic [DATA_W-1:0] fp_s_dat_o;
  logic [SEL_W-1:0]  fp_s_sel_o;
  logic [1:0]        fp_grant_o;

  int   total;
  int   bad;
  int   vidx;
  vec_t vecs[$];
  vec_t exp_q[$];

  wb_core_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4), .ROUND_ROBIN(1)) dut (
    .clk(clk), .rstn_i(rstn_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o)
  );

  wb_core_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4), .ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rstn_i(rstn_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_dat_o(fp_m0_dat_o), .m0_ack_o(fp_m0_ack_o), .m0_err_o(fp_m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_dat_o(fp_m1_dat_o), .m1_ack_o(fp_m1_ack_o), .m1_err_o(fp_m1_err_o),
    .s_cyc_o(fp_s_cyc_o), .s_stb_o(fp_s_stb_o), .s_we_o(fp_s_we_o), .s_adr_o(fp_s_adr_o), .s_dat_o(fp_s_dat_o),
    .s_sel_o(fp_s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(fp_grant_o)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic rstn, input logic [2:0] m0, input logic [2:0] m1,
                              input logic [1:0] se, input logic [1:0] fwd, input logic [1:0] gnt,
                              input logic [3:0] ae, input logic [2:0] fp);
    vec_t v;
    v.rstn = rstn; v.m0 = m0; v.m1 = m1; v.se = se;
    v.fwd = fwd; v.gnt = gnt; v.ae = ae; v.fp = fp;
    return v;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue its expectations
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rstn_i = v.rstn;
    {m0_cyc_i, m0_stb_i, m0_we_i} = v.m0;
    {m1_cyc_i, m1_stb_i, m1_we_i} = v.m1;
    {s_ack_i, s_err_i} = v.se;
    exp_q.push_back(v);
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL v%0d %s: got %h expected %h", vidx, name, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the outputs mid-cycle
  task automatic checkOutput();
    vec_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL v%0d scoreboard: got empty queue expected an entry", vidx);
      return;
    end
    e = exp_q.pop_front();
    case (e.fwd)
      F_M0: begin
        checkField("s_cyc", s_cyc_o, e.m0[2]);
        checkField("s_stb", s_stb_o, e.m0[1]);
        checkField("s_we", s_we_o, e.m0[0]);
        checkField("s_adr", s_adr_o, M0_ADR);
        checkField("s_dat", s_dat_o, M0_DAT);
        checkField("s_sel", s_sel_o, M0_SEL);
        checkField("m0_dat", m0_dat_o, S_DAT);
        checkField("m1_dat", m1_dat_o, 0);
      end
      F_M1: begin
        checkField("s_cyc", s_cyc_o, e.m1[2]);
        checkField("s_stb", s_stb_o, e.m1[1]);
        checkField("s_we", s_we_o, e.m1[0]);
        checkField("s_adr", s_adr_o, M1_ADR);
        checkField("s_dat", s_dat_o, M1_DAT);
        checkField("s_sel", s_sel_o, M1_SEL);
        checkField("m1_dat", m1_dat_o, S_DAT);
        checkField("m0_dat", m0_dat_o, 0);
      end
      F_NONE: begin
        checkField("s_cyc", s_cyc_o, 0);
        checkField("s_stb", s_stb_o, 0);
        checkField("m0_dat", m0_dat_o, 0);
        checkField("m1_dat", m1_dat_o, 0);
      end
      default: begin
        checkField("s_cyc", s_cyc_o, 0);
        checkField("s_stb", s_stb_o, 0);
      end
    endcase
    checkField("grant", grant_o, e.gnt);
    checkField("m0_ack", m0_ack_o, e.ae[3]);
    checkField("m0_err", m0_err_o, e.ae[2]);
    checkField("m1_ack", m1_ack_o, e.ae[1]);
    checkField("m1_err", m1_err_o, e.ae[0]);
    if (e.fp[2]) checkField("fp_grant", fp_grant_o, e.fp[1:0]);
    vidx++;
  endtask

  initial begin
    total = 0;
    bad = 0;
    vidx = 0;
    rstn_i = 1'b0;
    {m0_cyc_i, m0_stb_i, m0_we_i} = 3'b000;
    {m1_cyc_i, m1_stb_i, m1_we_i} = 3'b000;
    {s_ack_i, s_err_i} = 2'b00;
    m0_adr_i = M0_ADR; m0_dat_i = M0_DAT; m0_sel_i = M0_SEL;
    m1_adr_i = M1_ADR; m1_dat_i = M1_DAT; m1_sel_i = M1_SEL;
    s_dat_i = S_DAT;

    // reset state
    vecs.push_back(mk(0, 3'b000, 3'b000, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b100));
    // single m0 read, ack on the third cycle after the request
    vecs.push_back(mk(1, 3'b110, 3'b000, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b100));
    vecs.push_back(mk(1, 3'b110, 3'b000, 2'b00, F_M0,   2'b01, 4'b0000, 3'b101));
    vecs.push_back(mk(1, 3'b110, 3'b000, 2'b00, F_M0,   2'b01, 4'b0000, 3'b101));
    vecs.push_back(mk(1, 3'b110, 3'b000, 2'b10, F_M0,   2'b01, 4'b1000, 3'b101));
    vecs.push_back(mk(1, 3'b000, 3'b000, 2'b00, F_M0,   2'b01, 4'b0000, 3'b101));
    vecs.push_back(mk(1, 3'b000, 3'b000, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b100));
    // three contentions after reset: RR gives m0,m1,m0 and fixed priority m0 each time
    vecs.push_back(mk(0, 3'b110, 3'b110, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b100));
    vecs.push_back(mk(1, 3'b110, 3'b110, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b100));
    vecs.push_back(mk(1, 3'b110, 3'b110, 2'b10, F_M0,   2'b01, 4'b1000, 3'b101));
    vecs.push_back(mk(1, 3'b000, 3'b110, 2'b00, F_M0,   2'b01, 4'b0000, 3'b101));
    vecs.push_back(mk(1, 3'b110, 3'b110, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b100));
    vecs.push_back(mk(1, 3'b110, 3'b110, 2'b10, F_M1,   2'b10, 4'b0010, 3'b101));
    vecs.push_back(mk(1, 3'b000, 3'b000, 2'b00, F_M1,   2'b10, 4'b0000, 3'b101));
    vecs.push_back(mk(1, 3'b110, 3'b110, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b100));
    vecs.push_back(mk(1, 3'b110, 3'b110, 2'b10, F_M0,   2'b01, 4'b1000, 3'b101));
    vecs.push_back(mk(1, 3'b000, 3'b000, 2'b00, F_M0,   2'b01, 4'b0000, 3'b101));
    // m1 holds the grant for four ack beats while m0 keeps requesting
    vecs.push_back(mk(1, 3'b110, 3'b111, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b110, 3'b111, 2'b10, F_M1,   2'b10, 4'b0010, 3'b000));
    vecs.push_back(mk(1, 3'b110, 3'b101, 2'b00, F_M1,   2'b10, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b110, 3'b111, 2'b10, F_M1,   2'b10, 4'b0010, 3'b000));
    vecs.push_back(mk(1, 3'b110, 3'b111, 2'b10, F_M1,   2'b10, 4'b0010, 3'b000));
    vecs.push_back(mk(1, 3'b110, 3'b111, 2'b10, F_M1,   2'b10, 4'b0010, 3'b000));
    vecs.push_back(mk(1, 3'b110, 3'b000, 2'b00, F_M1,   2'b10, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b110, 3'b000, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b000, 3'b000, 2'b00, F_M0,   2'b01, 4'b0000, 3'b000));
    // slave error on m1 terminates the beat but keeps the grant
    vecs.push_back(mk(1, 3'b000, 3'b110, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b000, 3'b110, 2'b01, F_M1,   2'b10, 4'b0001, 3'b000));
    vecs.push_back(mk(1, 3'b000, 3'b110, 2'b00, F_M1,   2'b10, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b000, 3'b110, 2'b10, F_M1,   2'b10, 4'b0010, 3'b000));
    vecs.push_back(mk(1, 3'b000, 3'b000, 2'b00, F_M1,   2'b10, 4'b0000, 3'b000));
    // m0 write never acked: err on the 4th stall, abort until m0 drops, then m1
    vecs.push_back(mk(1, 3'b111, 3'b110, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b111, 3'b110, 2'b00, F_M0,   2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b111, 3'b110, 2'b00, F_M0,   2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b111, 3'b110, 2'b00, F_M0,   2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b111, 3'b110, 2'b00, F_M0,   2'b01, 4'b0100, 3'b000));
    vecs.push_back(mk(1, 3'b111, 3'b110, 2'b00, F_ABT,  2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b111, 3'b110, 2'b00, F_ABT,  2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b000, 3'b110, 2'b00, F_ABT,  2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b000, 3'b110, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b000, 3'b110, 2'b10, F_M1,   2'b10, 4'b0010, 3'b000));
    vecs.push_back(mk(1, 3'b000, 3'b000, 2'b00, F_M1,   2'b10, 4'b0000, 3'b000));
    // ack landing on the 4th stall wins over the timeout and clears the count
    vecs.push_back(mk(1, 3'b111, 3'b000, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b111, 3'b000, 2'b00, F_M0,   2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b111, 3'b000, 2'b00, F_M0,   2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b111, 3'b000, 2'b00, F_M0,   2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b111, 3'b000, 2'b10, F_M0,   2'b01, 4'b1000, 3'b000));
    vecs.push_back(mk(1, 3'b111, 3'b000, 2'b00, F_M0,   2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b000, 3'b000, 2'b00, F_M0,   2'b01, 4'b0000, 3'b000));
    // reset during an m0 transfer, spurious ack afterwards, then contention goes to m0
    vecs.push_back(mk(1, 3'b110, 3'b000, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b000));
    vecs.push_back(mk(0, 3'b110, 3'b110, 2'b00, F_M0,   2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b110, 3'b110, 2'b10, F_NONE, 2'b00, 4'b0000, 3'b100));
    vecs.push_back(mk(1, 3'b110, 3'b110, 2'b00, F_M0,   2'b01, 4'b0000, 3'b101));
    vecs.push_back(mk(1, 3'b000, 3'b000, 2'b00, F_M0,   2'b01, 4'b0000, 3'b000));
    vecs.push_back(mk(1, 3'b000, 3'b000, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b000));

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // STB low between stalls resets the timeout count, so only the later run aborts
    applyStimulus(mk(1, 3'b110, 3'b000, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b000)); checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(1, 3'b110, 3'b000, 2'b00, F_M0, 2'b01, 4'b0000, 3'b000)); checkOutput();
    end
    applyStimulus(mk(1, 3'b100, 3'b000, 2'b00, F_M0, 2'b01, 4'b0000, 3'b000)); checkOutput();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(1, 3'b110, 3'b000, 2'b00, F_M0, 2'b01, 4'b0000, 3'b000)); checkOutput();
    end
    applyStimulus(mk(1, 3'b110, 3'b000, 2'b00, F_M0,   2'b01, 4'b0100, 3'b000)); checkOutput();
    applyStimulus(mk(1, 3'b000, 3'b000, 2'b00, F_ABT,  2'b01, 4'b0000, 3'b000)); checkOutput();
    applyStimulus(mk(1, 3'b000, 3'b000, 2'b00, F_NONE, 2'b00, 4'b0000, 3'b000)); checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
